// File: rtl/bk_pkg.sv
// Shared constants and types for the Brent-Kung subtractor slice.
// Optional signed-overflow output is enabled by defining BK_SUB_OVF_EN.
package bk_pkg;

    localparam int WIDTH   = 6;
    localparam int LATENCY = 2;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/bk_prefix_cell.sv
// One Brent-Kung prefix operator: black (G and P) or grey (G only, GREY=1).
// Macro BK_SUB_OVF_EN does not affect this cell.
module bk_prefix_cell
    import bk_pkg::*;
#(
    parameter bit GREY = 1'b0
) (
    input  logic i_gHi,
    input  logic i_pHi,
    input  logic i_gLo,
    input  logic i_pLo,
    output logic o_g,
    output logic o_p
);

    assign o_g = i_gHi | (i_pHi & i_gLo);

    // Grey cells sit on spans anchored at bit 0, where the group propagate is never consumed.
    generate
        if (GREY) begin : g_grey
            logic w_unusedPLo;
            assign w_unusedPLo = i_pLo;
            assign o_p         = 1'b0;
        end else begin : g_black
            assign o_p = i_pHi & i_pLo;
        end
    endgenerate

endmodule

// File: rtl/bk_subtractor.sv
// Two-stage pipelined 6-bit Brent-Kung subtractor (A + ~B + 1) with valid/ready handshake.
// Define BK_SUB_OVF_EN to add the pipelined signed-overflow output ovf.
module bk_subtractor
    import bk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef BK_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    word_t      w_g;
    word_t      w_p;
    word_t      w_h;
    logic       w_g00;
    logic       w_g10;
    logic       w_g32;
    logic       w_p32;
    logic       w_g54;
    logic       w_p54;
    logic [4:0] w_unusedP;

    logic       r_s1Valid;
    word_t      r_h;
    logic       r_g00;
    logic       r_g10;
    logic       r_g32;
    logic       r_p32;
    logic       r_g54;
    logic       r_p54;
    logic       r_g2;
    logic       r_p2;
    logic       r_g4;
    logic       r_p4;

    logic       w_g20;
    logic       w_g30;
    logic       w_g40;
    logic       w_g50;
    word_t      w_dNext;

    logic       r_outValid;
    word_t      r_d;
    logic       r_bout;

    logic       w_s1Adv;
    logic       w_s2Adv;

    assign w_g   = a & ~b;
    assign w_p   = a | ~b;
    assign w_h   = a ^ ~b;
    // The subtraction's carry-in of 1 is absorbed into bit 0's generate.
    assign w_g00 = w_g[0] | w_p[0];

    bk_prefix_cell #(.GREY(1'b1)) u_g10 (
        .i_gHi(w_g[1]), .i_pHi(w_p[1]), .i_gLo(w_g00), .i_pLo(1'b0),
        .o_g(w_g10), .o_p(w_unusedP[0])
    );
    bk_prefix_cell #(.GREY(1'b0)) u_gp32 (
        .i_gHi(w_g[3]), .i_pHi(w_p[3]), .i_gLo(w_g[2]), .i_pLo(w_p[2]),
        .o_g(w_g32), .o_p(w_p32)
    );
    bk_prefix_cell #(.GREY(1'b0)) u_gp54 (
        .i_gHi(w_g[5]), .i_pHi(w_p[5]), .i_gLo(w_g[4]), .i_pLo(w_p[4]),
        .o_g(w_g54), .o_p(w_p54)
    );

    bk_prefix_cell #(.GREY(1'b1)) u_g30 (
        .i_gHi(r_g32), .i_pHi(r_p32), .i_gLo(r_g10), .i_pLo(1'b0),
        .o_g(w_g30), .o_p(w_unusedP[1])
    );
    bk_prefix_cell #(.GREY(1'b1)) u_g50 (
        .i_gHi(r_g54), .i_pHi(r_p54), .i_gLo(w_g30), .i_pLo(1'b0),
        .o_g(w_g50), .o_p(w_unusedP[2])
    );
    bk_prefix_cell #(.GREY(1'b1)) u_g20 (
        .i_gHi(r_g2), .i_pHi(r_p2), .i_gLo(r_g10), .i_pLo(1'b0),
        .o_g(w_g20), .o_p(w_unusedP[3])
    );
    bk_prefix_cell #(.GREY(1'b1)) u_g40 (
        .i_gHi(r_g4), .i_pHi(r_p4), .i_gLo(w_g30), .i_pLo(1'b0),
        .o_g(w_g40), .o_p(w_unusedP[4])
    );

    // r_h[0] already holds h0 ^ 1, so it is the final difference bit 0.
    assign w_dNext = {r_h[5] ^ w_g40, r_h[4] ^ w_g30, r_h[3] ^ w_g20,
                      r_h[2] ^ r_g10, r_h[1] ^ r_g00, r_h[0]};

    assign w_s2Adv  = ~r_outValid | out_ready;
    assign w_s1Adv  = ~r_s1Valid | w_s2Adv;
    assign in_ready = w_s1Adv;

    assign out_valid = r_outValid;
    assign d         = r_d;
    assign bout      = r_bout;

    // Stage 1 captures local bit terms and the low-level prefix groups on each accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_h       <= '0;
            r_g00     <= 1'b0;
            r_g10     <= 1'b0;
            r_g32     <= 1'b0;
            r_p32     <= 1'b0;
            r_g54     <= 1'b0;
            r_p54     <= 1'b0;
            r_g2      <= 1'b0;
            r_p2      <= 1'b0;
            r_g4      <= 1'b0;
            r_p4      <= 1'b0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= in_valid;
            end
            if (in_valid && w_s1Adv) begin
                r_h   <= {w_h[5:1], ~w_h[0]};
                r_g00 <= w_g00;
                r_g10 <= w_g10;
                r_g32 <= w_g32;
                r_p32 <= w_p32;
                r_g54 <= w_g54;
                r_p54 <= w_p54;
                r_g2  <= w_g[2];
                r_p2  <= w_p[2];
                r_g4  <= w_g[4];
                r_p4  <= w_p[4];
            end
        end
    end

    // Stage 2 finishes the tree and holds its result while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_d        <= '0;
            r_bout     <= 1'b0;
        end else begin
            if (w_s2Adv) begin
                r_outValid <= r_s1Valid;
            end
            if (r_s1Valid && w_s2Adv) begin
                r_d    <= w_dNext;
                r_bout <= ~w_g50;
            end
        end
    end

`ifdef BK_SUB_OVF_EN
    logic r_a5;
    logic r_ovf;

    assign ovf = r_ovf;

    // Operands differ in sign exactly when h5 is 0; overflow if the result sign departs from A.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a5  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (in_valid && w_s1Adv) begin
                r_a5 <= a[5];
            end
            if (r_s1Valid && w_s2Adv) begin
                r_ovf <= ~r_h[5] & (w_dNext[5] ^ r_a5);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bk_subtractor.sv
// Scoreboard bench for bk_subtractor; define BK_SUB_OVF_EN to also check ovf.
// Expected results are queued on input acceptance and popped on output transfer.
module tb_bk_subtractor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] d;
    logic       bout;
`ifdef BK_SUB_OVF_EN
    logic       ovf;
`endif

    int         nCompared   = 0;
    int         nMismatched = 0;
    int         nPushed     = 0;
    int         nReceived   = 0;
    logic [7:0] expQ[$];
    bit         randomReady = 1'b0;
    logic       forceReady  = 1'b1;

    bk_subtractor dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout)
`ifdef BK_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular difference, unsigned borrow, signed range overflow.
    function automatic logic [7:0] model(input logic [5:0] x, input logic [5:0] y);
        logic [5:0] diff;
        logic       borrow;
        logic       ovfl;
        int         sd;
        diff   = x - y;
        borrow = (x < y);
        sd     = int'($signed(x)) - int'($signed(y));
        ovfl   = (sd < -32) || (sd > 31);
        return {ovfl, borrow, diff};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the pair was taken.
    task automatic applyStimulus(input logic [5:0] ia, input logic [5:0] ib);
        int waitCycles;
        waitCycles = 0;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        a        = 6'($urandom);
        b        = 6'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin : readyDriver
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = randomReady ? 1'($urandom_range(0, 1)) : forceReady;
        end
    end

    initial begin : monitor
        logic [7:0] expVal;
        forever begin
            @(negedge clk);
            if (rst) begin
                nPushed -= expQ.size();
                expQ.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("result with empty queue", 32'(expQ.size() != 0), 32'd1);
                    end else begin
                        expVal = expQ.pop_front();
                        nReceived++;
                        checkOutput("sb d", 32'(d), 32'(expVal[5:0]));
                        checkOutput("sb bout", 32'(bout), 32'(expVal[6]));
`ifdef BK_SUB_OVF_EN
                        checkOutput("sb ovf", 32'(ovf), 32'(expVal[7]));
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    expQ.push_back(model(a, b));
                    nPushed++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        logic [7:0] heldExp;
        int         drainCycles;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset d", 32'(d), 32'd0);
        checkOutput("reset bout", 32'(bout), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
`ifdef BK_SUB_OVF_EN
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #1;

        a        = 6'd13;
        b        = 6'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        idleCycle();
        @(negedge clk);
        checkOutput("lat2 out_valid", 32'(out_valid), 32'd1);
        checkOutput("lat2 d", 32'(d), 32'd9);
        checkOutput("lat2 bout", 32'(bout), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(6'd4, 6'd13);
        applyStimulus(6'd0, 6'd1);
        applyStimulus(6'd32, 6'd1);
        repeat (4) idleCycle();

        // Stall: stage 2 holds the first pair, stage 1 the second, third must wait.
        forceReady = 1'b0;
        heldExp    = model(6'd20, 6'd5);
        applyStimulus(6'd20, 6'd5);
        applyStimulus(6'd7, 6'd40);
        a        = 6'd63;
        b        = 6'd63;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("stall in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall d", 32'(d), 32'(heldExp[5:0]));
        @(negedge clk);
        checkOutput("hold in_ready", 32'(in_ready), 32'd0);
        checkOutput("hold d", 32'(d), 32'(heldExp[5:0]));
        checkOutput("hold bout", 32'(bout), 32'(heldExp[6]));
        @(posedge clk);
        #1;
        forceReady = 1'b1;
        applyStimulus(6'd63, 6'd63);
        applyStimulus(6'd31, 6'd33);
        applyStimulus(6'd1, 6'd2);
        repeat (5) idleCycle();

        // Reset with a pair in stage 1: it must never emerge.
        applyStimulus(6'd7, 6'd3);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset out_valid c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("post-reset out_valid c2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        randomReady = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            applyStimulus(6'(i >> 6), 6'(i));
            if (i % 97 == 0) idleCycle();
        end
        in_valid    = 1'b0;
        randomReady = 1'b0;
        forceReady  = 1'b1;

        drainCycles = 0;
        while (expQ.size() != 0 && drainCycles < 200) begin
            @(posedge clk);
            drainCycles++;
        end
        repeat (3) @(posedge clk);
        checkOutput("drain queue", 32'(expQ.size()), 32'd0);
        checkOutput("result count", 32'(nReceived), 32'(nPushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
